multi_line_buffer: RTL

MULTI_LINE_BUFFER -- requirements
Module: multi_line_buffer

---
 rtl/multi_line_buffer_if.sv | 50 +++++
 rtl/multi_line_buffer.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/multi_line_buffer_if.sv
// ----------------------------------------------------------------------------
// multi_line_buffer_if
//
// Purpose:
//    Bundles the pixel write stream and the tap-column read stream of the
//    multi-line buffer into one interface. Signal names keep the i_/o_
//    prefixes as seen from the buffer itself, so the buffer uses the
//    'slave' modport and whatever feeds and drains it uses 'master'.
//
// Signals:
//    i_wr_valid  write pixel present
//    i_wr_data   write pixel, WIDTH bits
//    o_wr_ready  buffer accepts the pixel this cycle
//    o_rd_valid  tap column valid
//    i_rd_ready  downstream consumes the tap column
//    o_rd_data   LINES+1 taps of WIDTH bits, tap 0 in the low bits
// ----------------------------------------------------------------------------
interface multi_line_buffer_if #(
   parameter int WIDTH = 8,
   parameter int LINES = 2
);

   logic                         i_wr_valid;
   logic [WIDTH-1:0]             i_wr_data;
   logic                         o_wr_ready;
   logic                         o_rd_valid;
   logic                         i_rd_ready;
   logic [WIDTH*(LINES+1)-1:0]   o_rd_data;

   // Producer/consumer side: drives the write stream and read-ready.
   modport master (
      output i_wr_valid,
      output i_wr_data,
      output i_rd_ready,
      input  o_wr_ready,
      input  o_rd_valid,
      input  o_rd_data
   );

   // Buffer side.
   modport slave (
      input  i_wr_valid,
      input  i_wr_data,
      input  i_rd_ready,
      output o_wr_ready,
      output o_rd_valid,
      output o_rd_data
   );

endinterface

// File: rtl/multi_line_buffer.sv
// ----------------------------------------------------------------------------
// multi_line_buffer
//
// Purpose:
//    Stores LINES circular line memories of up to MAX_DEPTH pixels and, for
//    every accepted pixel once enough lines are stored, emits a vertical tap
//    column: tap k is the pixel written k*depth accepted writes earlier,
//    tap 0 is the pixel being written now.
//
// Ports:
//    i_clk          single clock, rising edge
//    i_reset_n      asynchronous, active-low reset
//    i_load_depth   pulse: load i_depth as the active line length
//    i_depth        requested line length, legal range 1..MAX_DEPTH
//    i_flush        discard stored lines, keep the current depth
//    o_cfg_err      sticky flag set by an out-of-range i_depth load
//    o_fill_count   saturating fill counter (only with the macro below)
//    bus            write/read streams, multi_line_buffer_if.slave
//
// Optional feature:
//    Define MULTI_LINE_BUFFER_STATUS_EN to add the o_fill_count output.
// ----------------------------------------------------------------------------
module multi_line_buffer #(
   parameter int WIDTH     = 8,
   parameter int MAX_DEPTH = 512,
   parameter int LINES     = 2
) (
   input  logic                                  i_clk,
   input  logic                                  i_reset_n,
   input  logic                                  i_load_depth,
   input  logic [$clog2(MAX_DEPTH):0]            i_depth,
   input  logic                                  i_flush,
   output logic                                  o_cfg_err,
`ifdef MULTI_LINE_BUFFER_STATUS_EN
   output logic [$clog2(LINES*MAX_DEPTH+1)-1:0]  o_fill_count,
`endif
   multi_line_buffer_if.slave                    bus
);

   localparam int DEPTH_W = $clog2(MAX_DEPTH) + 1;
   localparam int ADDR_W  = (MAX_DEPTH > 1) ? $clog2(MAX_DEPTH) : 1;
   localparam int CNT_W   = $clog2(LINES*MAX_DEPTH + 1);
   localparam int COL_W   = WIDTH * (LINES + 1);

   typedef enum logic {
      FILL = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   ptr_q, ptr_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [DEPTH_W-1:0]  depth_q, depth_d;
   logic                rd_valid_q, rd_valid_d;
   logic [COL_W-1:0]    rd_data_q, rd_data_d;
   logic                cfg_err_q, cfg_err_d;

   logic [WIDTH-1:0]    mem_q [LINES][MAX_DEPTH];

   logic                wr_ready;
   logic                wr_fire;
   logic                depth_legal;
   logic [CNT_W-1:0]    fill_target;
   logic                ptr_at_end;
   logic [COL_W-1:0]    column;

   // Handshake and derived quantities. A write can only land when the output
   // register is free (or being drained this cycle) and no reconfiguration is
   // happening, so load/flush never race with a pixel. The column is tap 0 =
   // incoming pixel, tap k = what line k-1 holds at the shared address.
   always_comb begin
      wr_ready    = (!rd_valid_q || bus.i_rd_ready) && !i_load_depth && !i_flush;
      wr_fire     = bus.i_wr_valid && wr_ready;
      depth_legal = (i_depth >= DEPTH_W'(1)) && (i_depth <= DEPTH_W'(MAX_DEPTH));
      fill_target = CNT_W'(depth_q) * CNT_W'(LINES);
      ptr_at_end  = (DEPTH_W'(ptr_q) == (depth_q - DEPTH_W'(1)));
      column      = '0;
      column[WIDTH-1:0] = bus.i_wr_data;
      for (int k = 1; k <= LINES; k++) begin
         column[k*WIDTH +: WIDTH] = mem_q[k-1][ptr_q];
      end
   end

   // Next-state logic for the FILL/RUN machine and every register around it.
   // Load and flush share the same restart path; a load additionally updates
   // depth and the error flag depending on legality. During FILL the counter
   // climbs until it equals LINES*depth; the write that finds it there is the
   // first one whose taps are all real pixels, so it enters RUN and produces
   // a valid column. The counter then simply holds (saturates).
   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      cnt_d      = cnt_q;
      depth_d    = depth_q;
      rd_valid_d = rd_valid_q;
      rd_data_d  = rd_data_q;
      cfg_err_d  = cfg_err_q;

      if (i_load_depth || i_flush) begin
         state_d    = FILL;
         ptr_d      = '0;
         cnt_d      = '0;
         rd_valid_d = 1'b0;
         if (i_load_depth) begin
            if (depth_legal) begin
               depth_d   = i_depth;
               cfg_err_d = 1'b0;
            end else begin
               cfg_err_d = 1'b1;
            end
         end
      end else if (wr_fire) begin
         rd_data_d = column;
         ptr_d     = ptr_at_end ? '0 : ptr_q + ADDR_W'(1);
         if (state_q == RUN || cnt_q >= fill_target) begin
            state_d    = RUN;
            rd_valid_d = 1'b1;
         end else begin
            cnt_d      = cnt_q + CNT_W'(1);
            rd_valid_d = 1'b0;
         end
      end else if (bus.i_rd_ready) begin
         rd_valid_d = 1'b0;
      end
   end

   // Control and output registers. Reset restores the full line length and
   // drops any pending column immediately.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_q    <= FILL;
         ptr_q      <= '0;
         cnt_q      <= '0;
         depth_q    <= DEPTH_W'(MAX_DEPTH);
         rd_valid_q <= 1'b0;
         rd_data_q  <= '0;
         cfg_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         cnt_q      <= cnt_d;
         depth_q    <= depth_d;
         rd_valid_q <= rd_valid_d;
         rd_data_q  <= rd_data_d;
         cfg_err_q  <= cfg_err_d;
      end
   end

   // Line memories. Each accepted pixel shifts the column at the current
   // address down one line, so line k ends up holding the pixel from
   // (k+1)*depth writes ago. Contents are not reset; the fill counter keeps
   // stale data from ever reaching a valid column.
   always_ff @(posedge i_clk) begin
      if (wr_fire) begin
         mem_q[0][ptr_q] <= bus.i_wr_data;
         for (int k = 1; k < LINES; k++) begin
            mem_q[k][ptr_q] <= mem_q[k-1][ptr_q];
         end
      end
   end

   assign bus.o_wr_ready = wr_ready;
   assign bus.o_rd_valid = rd_valid_q;
   assign bus.o_rd_data  = rd_data_q;
   assign o_cfg_err      = cfg_err_q;

`ifdef MULTI_LINE_BUFFER_STATUS_EN
   assign o_fill_count = cnt_q;
`endif

endmodule
